// File: rtl/emib_mxs_link_model.sv
// EMIB bridge model between AIB master and slave dies: per-channel link-up sequencing, fault injection, corruption counters.
// Latency: LATENCY clk cycles per direction (data sampled at edge n is visible after edge n+LATENCY-1).
// Backpressure: none; data flows every cycle and lanes of channels not in UP enter the pipeline as zero.
module emib_mxs_link_model #(
    parameter int NUM_CH     = 24,
    parameter int M_W        = 102,
    parameter int S_W        = 96,
    parameter int LATENCY    = 2,
    parameter int SETTLE_CYC = 4,
    parameter int CNT_W      = 16,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int BIT_W     = (S_W > 1) ? $clog2(S_W) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*M_W-1:0]   m_tx,
    output logic [NUM_CH*M_W-1:0]   m_rx,
    input  logic [NUM_CH*S_W-1:0]   s_tx,
    output logic [NUM_CH*S_W-1:0]   s_rx,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic [NUM_CH-1:0]       link_up,
    input  logic                    fi_wr,
    input  logic                    fi_dir,
    input  logic [CH_W-1:0]         fi_ch,
    input  logic [BIT_W-1:0]        fi_bit,
    input  logic [1:0]              fi_mode,
    output logic                    fi_err,
    input  logic                    err_clr,
    output logic [CNT_W-1:0]        err_cnt_m2s,
    output logic [CNT_W-1:0]        err_cnt_s2m
);

    localparam int DW    = NUM_CH * S_W;
    localparam int IDX_W = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [1:0] ST_OFF    = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_UP     = 2'd2;

    localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic [1:0]    ch_st  [NUM_CH];
    logic [7:0]    ch_cnt [NUM_CH];

    logic [DW-1:0] m2s_in;
    logic [DW-1:0] s2m_in;
    logic [DW-1:0] m2s_pipe [LATENCY];
    logic [DW-1:0] s2m_pipe [LATENCY];
    logic [DW-1:0] m2s_out;
    logic [DW-1:0] s2m_out;

    logic             flt_vld;
    logic             flt_dir;
    logic [CH_W-1:0]  flt_ch;
    logic [BIT_W-1:0] flt_bit;
    logic [1:0]       flt_mode;
    logic [IDX_W-1:0] flt_idx;
    logic [DW-1:0]    flt_mask;
    logic             fi_ok;
    logic             m2s_corrupt;
    logic             s2m_corrupt;

    // Force the selected bit according to the fault mode; untouched when the fault does not target this path.
    function automatic logic [DW-1:0] apply_fault(input logic [DW-1:0] d, input logic hit,
                                                  input logic [1:0] mode, input logic [DW-1:0] mask);
        logic [DW-1:0] r;
        r = d;
        if (hit) begin
            case (mode)
                2'd1:    r = d & ~mask;
                2'd2:    r = d | mask;
                2'd3:    r = d ^ mask;
                default: r = d;
            endcase
        end
        return r;
    endfunction

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        // Link-up sequencing: a dropped enable always restarts the settle count from the top.
        always_ff @(posedge clk) begin
            if (rst) begin
                ch_st[ch]  <= ST_OFF;
                ch_cnt[ch] <= '0;
            end else begin
                case (ch_st[ch])
                    ST_OFF: begin
                        if (ch_en[ch]) begin
                            ch_st[ch]  <= ST_SETTLE;
                            ch_cnt[ch] <= SETTLE_INIT;
                        end
                    end
                    ST_SETTLE: begin
                        if (!ch_en[ch]) begin
                            ch_st[ch] <= ST_OFF;
                        end else if (ch_cnt[ch] == 8'd0) begin
                            ch_st[ch] <= ST_UP;
                        end else begin
                            ch_cnt[ch] <= ch_cnt[ch] - 8'd1;
                        end
                    end
                    ST_UP: begin
                        if (!ch_en[ch]) begin
                            ch_st[ch] <= ST_OFF;
                        end
                    end
                    default: ch_st[ch] <= ST_OFF;
                endcase
            end
        end

        assign link_up[ch] = (ch_st[ch] == ST_UP);

        // Lanes of a channel that is not up cross as zero in both directions.
        assign m2s_in[ch*S_W +: S_W] = link_up[ch] ? m_tx[ch*M_W +: S_W] : '0;
        assign s2m_in[ch*S_W +: S_W] = link_up[ch] ? s_tx[ch*S_W +: S_W] : '0;

        assign m_rx[ch*M_W +: S_W] = s2m_out[ch*S_W +: S_W];
        if (M_W > S_W) begin : g_pad
            logic unused_m_tx_hi;
            assign unused_m_tx_hi = ^m_tx[ch*M_W+S_W +: M_W-S_W];
            assign m_rx[ch*M_W+S_W +: M_W-S_W] = '0;
        end
    end

    // Fixed-depth delay line per direction; reset flushes every stage in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LATENCY; s++) begin
                m2s_pipe[s] <= '0;
                s2m_pipe[s] <= '0;
            end
        end else begin
            m2s_pipe[0] <= m2s_in;
            s2m_pipe[0] <= s2m_in;
            for (int s = 1; s < LATENCY; s++) begin
                m2s_pipe[s] <= m2s_pipe[s-1];
                s2m_pipe[s] <= s2m_pipe[s-1];
            end
        end
    end

    assign fi_ok = (32'(fi_ch) < NUM_CH) && (32'(fi_bit) < S_W);

    // Single fault slot: an in-range write replaces it, an out-of-range write is rejected with a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            flt_vld  <= 1'b0;
            flt_dir  <= 1'b0;
            flt_ch   <= '0;
            flt_bit  <= '0;
            flt_mode <= 2'd0;
            fi_err   <= 1'b0;
        end else begin
            fi_err <= fi_wr && !fi_ok;
            if (fi_wr && fi_ok) begin
                flt_vld  <= (fi_mode != 2'd0);
                flt_dir  <= fi_dir;
                flt_ch   <= fi_ch;
                flt_bit  <= fi_bit;
                flt_mode <= fi_mode;
            end
        end
    end

    assign flt_idx  = IDX_W'(32'(flt_ch) * S_W + 32'(flt_bit));
    assign flt_mask = DW'(1) << flt_idx;

    assign m2s_out = apply_fault(m2s_pipe[LATENCY-1], flt_vld && !flt_dir, flt_mode, flt_mask);
    assign s2m_out = apply_fault(s2m_pipe[LATENCY-1], flt_vld &&  flt_dir, flt_mode, flt_mask);

    // A beat is corrupted only when the fault actually changes the bit this cycle.
    assign m2s_corrupt = (m2s_out != m2s_pipe[LATENCY-1]);
    assign s2m_corrupt = (s2m_out != s2m_pipe[LATENCY-1]);

    assign s_rx = m2s_out;

    // Saturating corruption counters; a clear takes priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_cnt_m2s <= '0;
            err_cnt_s2m <= '0;
        end else begin
            if (m2s_corrupt && err_cnt_m2s != CNT_MAX) begin
                err_cnt_m2s <= err_cnt_m2s + 1'b1;
            end
            if (s2m_corrupt && err_cnt_s2m != CNT_MAX) begin
                err_cnt_s2m <= err_cnt_s2m + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_emib_mxs_link_model.sv
// Bench for emib_mxs_link_model: random traffic against a delay-line reference with a per-channel enable-run model.
// Every tick compares all outputs one time unit after the rising edge.
// Directed steps cover settle timing, latency, enable glitches, fault modes, saturation, clear priority and reset.
module tb_emib_mxs_link_model;

    localparam int NUM_CH = 24;
    localparam int M_W    = 102;
    localparam int S_W    = 96;
    localparam int LAT    = 3;
    localparam int SETTLE = 4;
    localparam int CNT_W  = 8;
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int BIT_W  = $clog2(S_W);
    localparam int DW     = NUM_CH * S_W;
    localparam int VW     = NUM_CH * M_W;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [VW-1:0]        m_tx;
    logic [VW-1:0]        m_rx;
    logic [DW-1:0]        s_tx;
    logic [DW-1:0]        s_rx;
    logic [NUM_CH-1:0]    ch_en;
    logic [NUM_CH-1:0]    link_up;
    logic                 fi_wr;
    logic                 fi_dir;
    logic [CH_W-1:0]      fi_ch;
    logic [BIT_W-1:0]     fi_bit;
    logic [1:0]           fi_mode;
    logic                 fi_err;
    logic                 err_clr;
    logic [CNT_W-1:0]     err_cnt_m2s;
    logic [CNT_W-1:0]     err_cnt_s2m;

    int total = 0;
    int bad   = 0;

    // Reference state
    int            run [NUM_CH];
    logic [DW-1:0] q_m2s [$];
    logic [DW-1:0] q_s2m [$];
    bit            f_vld;
    bit            f_dir;
    int            f_ch;
    int            f_bit;
    logic [1:0]    f_mode;
    logic          e_fi_err;
    int            e_cm;
    int            e_cs;

    emib_mxs_link_model #(
        .NUM_CH(NUM_CH), .M_W(M_W), .S_W(S_W), .LATENCY(LAT), .SETTLE_CYC(SETTLE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .m_tx(m_tx), .m_rx(m_rx), .s_tx(s_tx), .s_rx(s_rx),
        .ch_en(ch_en), .link_up(link_up),
        .fi_wr(fi_wr), .fi_dir(fi_dir), .fi_ch(fi_ch), .fi_bit(fi_bit), .fi_mode(fi_mode),
        .fi_err(fi_err), .err_clr(err_clr),
        .err_cnt_m2s(err_cnt_m2s), .err_cnt_s2m(err_cnt_s2m)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        int idx;
        total++;
        assert (obs === exp) else begin
            bad++;
            idx = -1;
            for (int i = 0; i < VW; i++) begin
                if (obs[i] !== exp[i]) begin
                    idx = i;
                    break;
                end
            end
            $error("FAIL %s at t=%0t first diff bit %0d: observed low64=%h expected low64=%h",
                   tag, $time, idx, obs[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [DW-1:0] ref_fault(input logic [DW-1:0] d, input bit dir);
        logic [DW-1:0] r;
        int idx;
        r = d;
        if (f_vld && f_dir == dir) begin
            idx = f_ch * S_W + f_bit;
            case (f_mode)
                2'd1:    r[idx] = 1'b0;
                2'd2:    r[idx] = 1'b1;
                2'd3:    r[idx] = ~d[idx];
                default: r[idx] = d[idx];
            endcase
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] widen(input logic [DW-1:0] d);
        logic [VW-1:0] r;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) r[c*M_W +: S_W] = d[c*S_W +: S_W];
        return r;
    endfunction

    task automatic reset_model();
        for (int c = 0; c < NUM_CH; c++) run[c] = 0;
        q_m2s.delete();
        q_s2m.delete();
        for (int s = 0; s < LAT; s++) begin
            q_m2s.push_back('0);
            q_s2m.push_back('0);
        end
        f_vld    = 1'b0;
        e_fi_err = 1'b0;
        e_cm     = 0;
        e_cs     = 0;
    endtask

    task automatic rnd();
        logic [VW+31:0] t;
        t = '0;
        for (int k = 0; k < (VW + 31) / 32; k++) t = {t[VW-1:0], $urandom};
        m_tx = t[VW-1:0];
        for (int k = 0; k < (DW + 31) / 32; k++) t = {t[VW-1:0], $urandom};
        s_tx = t[DW-1:0];
    endtask

    // One clock: predict from pre-edge inputs, advance the reference, then compare every output.
    task automatic tick();
        logic [DW-1:0]     nm, ns, cur_m, cur_s;
        logic [NUM_CH-1:0] lu;
        bit                cor_m, cor_s;
        cur_m = ref_fault(q_m2s[0], 1'b0);
        cur_s = ref_fault(q_s2m[0], 1'b1);
        cor_m = (cur_m !== q_m2s[0]);
        cor_s = (cur_s !== q_s2m[0]);
        for (int c = 0; c < NUM_CH; c++) begin
            nm[c*S_W +: S_W] = (run[c] > SETTLE) ? m_tx[c*M_W +: S_W] : '0;
            ns[c*S_W +: S_W] = (run[c] > SETTLE) ? s_tx[c*S_W +: S_W] : '0;
        end
        @(posedge clk);
        if (rst) begin
            reset_model();
        end else begin
            q_m2s.push_back(nm);
            void'(q_m2s.pop_front());
            q_s2m.push_back(ns);
            void'(q_s2m.pop_front());
            for (int c = 0; c < NUM_CH; c++) run[c] = ch_en[c] ? ((run[c] < 1000) ? run[c] + 1 : run[c]) : 0;
            e_fi_err = 1'b0;
            if (fi_wr) begin
                if (int'(fi_ch) < NUM_CH && int'(fi_bit) < S_W) begin
                    f_vld  = (fi_mode != 2'd0);
                    f_dir  = fi_dir;
                    f_ch   = int'(fi_ch);
                    f_bit  = int'(fi_bit);
                    f_mode = fi_mode;
                end else begin
                    e_fi_err = 1'b1;
                end
            end
            if (err_clr) begin
                e_cm = 0;
                e_cs = 0;
            end else begin
                if (cor_m && e_cm < CMAX) e_cm++;
                if (cor_s && e_cs < CMAX) e_cs++;
            end
        end
        #1;
        for (int c = 0; c < NUM_CH; c++) lu[c] = (run[c] > SETTLE);
        chk("link_up", VW'(link_up), VW'(lu));
        chk("s_rx", VW'(s_rx), VW'(ref_fault(q_m2s[0], 1'b0)));
        chk("m_rx", m_rx, widen(ref_fault(q_s2m[0], 1'b1)));
        chk("fi_err", VW'(fi_err), VW'(e_fi_err));
        chk("err_cnt_m2s", VW'(err_cnt_m2s), VW'(e_cm));
        chk("err_cnt_s2m", VW'(err_cnt_s2m), VW'(e_cs));
    endtask

    task automatic fault_wr(input logic dir, input int ch, input int bitn, input logic [1:0] mode);
        fi_wr   = 1'b1;
        fi_dir  = dir;
        fi_ch   = CH_W'(ch);
        fi_bit  = BIT_W'(bitn);
        fi_mode = mode;
        rnd();
        tick();
        fi_wr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ch_en = '0; m_tx = '0; s_tx = '0;
        fi_wr = 1'b0; fi_dir = 1'b0; fi_ch = '0; fi_bit = '0; fi_mode = 2'd0; err_clr = 1'b0;
        reset_model();
        tick();
        tick();
        chk("reset_cnt", VW'({err_cnt_m2s, err_cnt_s2m}), '0);

        // Bring all channels up: low for SETTLE edges after the enable edge, high after the next.
        rst = 1'b0;
        ch_en = '1;
        for (int i = 0; i < SETTLE; i++) begin
            rnd();
            tick();
            chk("settle_low", VW'(link_up), '0);
            chk("settle_s_rx", VW'(s_rx), '0);
        end
        rnd();
        tick();
        chk("settle_up", VW'(link_up), VW'({NUM_CH{1'b1}}));

        repeat (20) begin rnd(); tick(); end

        // Directed latency: a marker on channel 5 shows up LAT edges after it is sampled.
        rnd();
        m_tx[5*M_W +: 8] = 8'hA5;
        tick();
        for (int i = 1; i < LAT; i++) begin rnd(); tick(); end
        chk("lat_a5", VW'(s_rx[5*S_W +: 8]), VW'(8'hA5));

        // Enable drops while channel 2 is settling with one count left; re-raise restarts the full settle.
        ch_en[2] = 1'b0; rnd(); tick();
        ch_en[2] = 1'b1;
        repeat (3) begin rnd(); tick(); end
        ch_en[2] = 1'b0; rnd(); tick();
        ch_en[2] = 1'b1;
        for (int i = 0; i < SETTLE; i++) begin
            rnd();
            tick();
            chk("reraise_low", VW'(link_up[2]), '0);
        end
        rnd();
        tick();
        chk("reraise_up", VW'(link_up[2]), VW'(1'b1));

        // Random enable churn, then everything back up.
        repeat (60) begin
            for (int c = 0; c < NUM_CH; c++) if ($urandom_range(0, 15) == 0) ch_en[c] = ~ch_en[c];
            rnd();
            tick();
        end
        ch_en = '1;
        repeat (SETTLE + 2) begin rnd(); tick(); end

        // Invert m2s ch3 bit7: every beat corrupts.
        fault_wr(1'b0, 3, 7, 2'd3);
        err_clr = 1'b1; rnd(); tick(); err_clr = 1'b0;
        repeat (100) begin rnd(); tick(); end
        chk("inv_100", VW'(err_cnt_m2s), VW'(8'd100));
        repeat (200) begin rnd(); tick(); end
        chk("saturate", VW'(err_cnt_m2s), VW'(CMAX));
        err_clr = 1'b1; rnd(); tick(); err_clr = 1'b0;
        chk("clr_wins", VW'(err_cnt_m2s), '0);

        // Rejected writes leave the invert fault in place.
        fault_wr(1'b1, NUM_CH, 0, 2'd2);
        chk("oor_ch_err", VW'(fi_err), VW'(1'b1));
        rnd(); tick();
        chk("oor_pulse_end", VW'(fi_err), '0);
        fault_wr(1'b0, 0, S_W, 2'd1);
        chk("oor_bit_err", VW'(fi_err), VW'(1'b1));
        repeat (5) begin rnd(); tick(); end

        // Stuck-0 on a bit that is always 0 never counts.
        fault_wr(1'b0, 3, 7, 2'd1);
        repeat (LAT + 2) begin rnd(); m_tx[3*M_W+7] = 1'b0; tick(); end
        err_clr = 1'b1; rnd(); m_tx[3*M_W+7] = 1'b0; tick(); err_clr = 1'b0;
        repeat (10) begin rnd(); m_tx[3*M_W+7] = 1'b0; tick(); end
        chk("stuck0_quiet", VW'(err_cnt_m2s), '0);

        // Stuck-1 on s2m path, then clear the fault.
        fault_wr(1'b1, 0, S_W - 1, 2'd2);
        repeat (30) begin rnd(); tick(); end
        fault_wr(1'b0, 0, 0, 2'd0);
        repeat (10) begin rnd(); tick(); end

        // Reset in the middle of faulted traffic, with competing controls asserted.
        fault_wr(1'b0, 1, 3, 2'd3);
        repeat (10) begin rnd(); tick(); end
        rst = 1'b1; fi_wr = 1'b1; fi_ch = CH_W'(2); fi_bit = BIT_W'(1); fi_mode = 2'd3; err_clr = 1'b0;
        rnd();
        tick();
        chk("rst_s_rx", VW'(s_rx), '0);
        chk("rst_m_rx", m_rx, '0);
        chk("rst_link", VW'(link_up), '0);
        chk("rst_cnt", VW'({err_cnt_m2s, err_cnt_s2m}), '0);
        rst = 1'b0; fi_wr = 1'b0;
        repeat (SETTLE + LAT + 3) begin rnd(); tick(); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
